// File: rtl/dig_display_ctrl.sv
// Eight-digit seven-segment display controller: a memory-mapped 32-bit display
// register, time-multiplexed onto a common-anode, active-low digit/segment bus.
module dig_display_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int LZ_BLANK = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [7:0]  dig_en,
  output logic [7:0]  seg
);

  localparam int          CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [31:0] DISP_ADDR = 32'hFFFF_F000;

  logic [31:0]      r_disp;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_dig_en;
  logic [7:0]       r_seg;

  logic [3:0]       w_nib;
  logic [7:0]       w_zero_from;
  logic             w_blank;
  logic [7:0]       w_seg;
  logic             w_wrap;
  logic             w_wr_hit;

  // Hex nibble to active-low {DP,G,F,E,D,C,B,A}; DP stays dark.
  function automatic logic [7:0] hex7(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'h88;
      4'hB:    s = 8'h83;
      4'hC:    s = 8'hC6;
      4'hD:    s = 8'hA1;
      4'hE:    s = 8'h86;
      4'hF:    s = 8'h8E;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  assign w_wr_hit = we && (addr == DISP_ADDR);
  assign w_wrap   = (r_cnt == CNT_W'(SCAN_DIV - 1));
  assign w_nib    = r_disp[{r_idx, 2'b00} +: 4];

  // w_zero_from[i] is set when nibbles i..7 are all zero (leading-zero run).
  always_comb begin
    w_zero_from    = 8'h00;
    w_zero_from[7] = (r_disp[31:28] == 4'h0);
    for (int i = 6; i >= 0; i--) begin
      w_zero_from[i] = w_zero_from[i+1] && (r_disp[4*i +: 4] == 4'h0);
    end
  end

  // Digit 0 is never blanked so an all-zero value still shows a single 0.
  always_comb begin
    w_blank = 1'b0;
    w_seg   = 8'hFF;
    if ((LZ_BLANK != 0) && (r_idx != 3'd0)) begin
      w_blank = w_zero_from[r_idx];
    end else begin
      w_blank = 1'b0;
    end
    w_seg = w_blank ? 8'hFF : hex7(w_nib);
  end

  // Display register, scan divider/digit index and registered pin drivers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_disp   <= 32'h0000_0000;
      r_cnt    <= '0;
      r_idx    <= 3'd0;
      r_dig_en <= 8'hFF;
      r_seg    <= 8'hFF;
    end else begin
      if (w_wr_hit) begin
        r_disp <= wdata;
      end
      if (w_wrap) begin
        r_cnt <= '0;
        r_idx <= r_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      r_dig_en <= ~(8'b0000_0001 << r_idx);
      r_seg    <= w_seg;
    end
  end

  assign dig_en = r_dig_en;
  assign seg    = r_seg;

endmodule

// File: tb/tb_dig_display_ctrl.sv
// Scoreboard bench: two controllers (plain and leading-zero blanking) share one
// bus; expected pin values are queued against (reset epoch, edge count).
module tb_dig_display_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = 32'h0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [7:0]  dig_a, seg_a, dig_b, seg_b;

  int cyc = 0;
  int epoch = 1;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int         ep;
    int         cy;
    int         inst;
    logic [7:0] dig;
    logic [7:0] seg;
  } exp_t;
  exp_t sb[$];

  logic [7:0] frame1 [8] = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};

  dig_display_ctrl #(.SCAN_DIV(4), .LZ_BLANK(0)) u_a (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .wdata(wdata),
    .dig_en(dig_a), .seg(seg_a));

  dig_display_ctrl #(.SCAN_DIV(4), .LZ_BLANK(1)) u_b (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .wdata(wdata),
    .dig_en(dig_b), .seg(seg_b));

  always #5 clk = ~clk;

  // Edges since the most recent reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic push(input int ep, input int cy, input int inst,
                      input logic [7:0] d, input logic [7:0] s);
    exp_t e;
    e.ep = ep; e.cy = cy; e.inst = inst; e.dig = d; e.seg = s;
    sb.push_back(e);
  endtask

  task automatic push2(input int ep, input int cy, input logic [7:0] d,
                       input logic [7:0] sa, input logic [7:0] sbv);
    push(ep, cy, 0, d, sa);
    push(ep, cy, 1, d, sbv);
  endtask

  function automatic logic [7:0] dmask(input int d);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << d);
  endfunction

  task automatic do_write(input int edge_k, input logic [31:0] a, input logic [31:0] d);
    while (cyc < edge_k - 1) @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0; addr = 32'h0; wdata = 32'h0;
  endtask

  // Monitor: compare every queued expectation at its (epoch, edge) sample point.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && (sb[0].ep < epoch || (sb[0].ep == epoch && sb[0].cy < cyc))) begin
        n_vec++; n_bad++;
        $display("FAIL missed_e%0d_c%0d_i%0d: sample point never reached (now e%0d c%0d)",
                 sb[0].ep, sb[0].cy, sb[0].inst, epoch, cyc);
        void'(sb.pop_front());
      end
      while (sb.size() > 0 && sb[0].ep == epoch && sb[0].cy == cyc) begin
        logic [7:0] ad, as;
        ad = (sb[0].inst == 0) ? dig_a : dig_b;
        as = (sb[0].inst == 0) ? seg_a : seg_b;
        n_vec++;
        if (ad !== sb[0].dig || as !== sb[0].seg) begin
          n_bad++;
          $display("FAIL e%0d_c%0d_i%0d: got dig_en/seg=%h/%h required %h/%h",
                   sb[0].ep, sb[0].cy, sb[0].inst, ad, as, sb[0].dig, sb[0].seg);
        end
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    push2(1, 0, 8'hFF, 8'hFF, 8'hFF);
    for (int j = 0; j < 8; j++) begin
      push2(1, 1 + 4*j, dmask(j), 8'hC0, (j == 0) ? 8'hC0 : 8'hFF);
      push2(1, 4 + 4*j, dmask(j), 8'hC0, (j == 0) ? 8'hC0 : 8'hFF);
    end
    push2(1, 33, 8'hFE, 8'hC0, 8'hC0);
    for (int j = 0; j < 8; j++)
      push2(1, 42 + 4*j, dmask((2 + j) % 8), frame1[(2 + j) % 8], frame1[(2 + j) % 8]);
    for (int j = 0; j < 8; j++)
      push2(1, 82 + 4*j, dmask((4 + j) % 8), frame1[(4 + j) % 8], frame1[(4 + j) % 8]);
    push2(1, 129, 8'hFE, 8'h8E, 8'h8E);
    push2(1, 130, 8'hFE, 8'h92, 8'h92);
    for (int j = 0; j < 7; j++)
      push2(1, 134 + 4*j, dmask(1 + j), 8'hC0, 8'hFF);
    for (int j = 0; j < 8; j++) begin
      int d;
      logic [7:0] sa, sbv;
      d = (2 + j) % 8;
      sa = (d == 1) ? 8'hA4 : (d == 2) ? 8'hF9 : 8'hC0;
      sbv = (d == 0) ? 8'hC0 : (d == 1) ? 8'hA4 : (d == 2) ? 8'hF9 : 8'hFF;
      push2(1, 172 + 4*j, dmask(d), sa, sbv);
    end
    for (int j = 0; j < 8; j++) begin
      int d;
      d = (4 + j) % 8;
      push2(1, 212 + 4*j, dmask(d), 8'hC0, (d == 0) ? 8'hC0 : 8'hFF);
    end
    push2(1, 262, 8'hFD, 8'hC0, 8'hFF);
    push2(1, 263, 8'hFD, 8'h8E, 8'h8E);
    push2(1, 278, 8'hDF, 8'hC0, 8'hFF);
    push2(2, 0, 8'hFF, 8'hFF, 8'hFF);
    push2(2, 1, 8'hFE, 8'hC0, 8'hC0);
    push2(2, 4, 8'hFE, 8'hC0, 8'hC0);
    push2(2, 5, 8'hFD, 8'hC0, 8'hFF);

    repeat (3) @(negedge clk);
    n_vec++;
    if (dig_a !== 8'hFF || seg_a !== 8'hFF || dig_b !== 8'hFF || seg_b !== 8'hFF) begin
      n_bad++;
      $display("FAIL in_reset: got %h/%h %h/%h required FF/FF", dig_a, seg_a, dig_b, seg_b);
    end
    rst = 1'b1;
    do_write(40, 32'hFFFF_F000, 32'h89AB_CDEF);
    do_write(80, 32'hFFFF_F004, 32'h1234_5678);
    do_write(129, 32'hFFFF_F000, 32'h0000_0005);
    do_write(170, 32'hFFFF_F000, 32'h0000_0120);
    do_write(210, 32'hFFFF_F000, 32'h0000_0000);
    do_write(262, 32'hFFFF_F000, 32'h0000_00F7);
    while (cyc < 278) @(negedge clk);
    @(posedge clk);
    #1;
    epoch = 2;
    rst = 1'b0;
    #1;
    n_vec++;
    if (dig_a !== 8'hFF || seg_a !== 8'hFF) begin
      n_bad++;
      $display("FAIL async_reset_a: got %h/%h required FF/FF before next edge", dig_a, seg_a);
    end
    n_vec++;
    if (dig_b !== 8'hFF || seg_b !== 8'hFF) begin
      n_bad++;
      $display("FAIL async_reset_b: got %h/%h required FF/FF before next edge", dig_b, seg_b);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      n_vec++; n_bad++;
      $display("FAIL unchecked_e%0d_c%0d_i%0d: expectation left in queue",
               sb[0].ep, sb[0].cy, sb[0].inst);
      void'(sb.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    n_bad++;
    $display("FAIL timeout: simulation time limit reached with %0d expectations pending", sb.size());
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dig_display_ctrl.md
# dig_display_ctrl

Memory-mapped 8-digit seven-segment display controller: the responder on the bridge's 7-seg port. It captures CPU store data written to 0xFFFF_F000 into a 32-bit display register. It then time-multiplexes the eight hex nibbles onto a common-anode, active-low digit/segment bus using a programmable scan divider. It sits between the bridge's `*_to_dig` outputs and the board pins.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clock cycles each digit stays lit (≥2).
- `LZ_BLANK`, default 0: when 1, leading-zero digits are blanked.

Ports:
- `clk`  in  1: system clock; single clock domain.
- `rst`  in  1: asynchronous, active-low reset (0 = in reset).
- `addr`  in  32: CPU byte address from bridge.
- `we`  in  1: write strobe from bridge (already gated to this port).
- `wdata`  in  32: CPU store data.
- `dig_en`  out  8: digit anodes, active-low; bit i = digit i; digit 0 is rightmost.
- `seg`  out  8: segments {DP,G,F,E,D,C,B,A}, active-low.

## Operation
- Write decode:
  - `disp` <= `wdata` on a rising edge with `we`=1 and `addr`=32'hFFFF_F000.
  - Any other address with `we`=1 is ignored.
  - There is no read path. Byte enables are not used; a write always updates the full word.
- Scan counter `cnt` (width clog2(SCAN_DIV)):
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - On the wrap cycle, digit index `idx` (3 bits) increments, 7 wraps to 0.
- Nibble select: digit `idx` shows `disp[4*idx+3 : 4*idx]`.
- Hex decode, active-low, DP always off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Leading-zero blanking (`LZ_BLANK`=1):
  - Digit i is blanked (`seg`=8'hFF; anode still driven) when i>0 and all nibbles i..7 are zero.
  - Digit 0 is never blanked.
- Outputs are registered every cycle:
  - `dig_en` <= ~(8'b1 << `idx`)
  - `seg` <= decode(nibble(`disp`, `idx`)), with blanking applied.

## Timing
- Reset values (asynchronous, while `rst`=0):
  - `disp`=0, `cnt`=0, `idx`=0
  - `dig_en`=8'hFF (all off), `seg`=8'hFF
- First edge after reset release: `dig_en`=8'hFE, `seg`=8'hC0.
- Output latency is one cycle behind `idx`/`disp`:
  - A write captured at edge N is visible on `seg` at edge N+1 if `idx` selects the affected digit.
  - Otherwise it appears when scanning reaches that digit.
- Digit dwell:
  - Each digit is lit for exactly SCAN_DIV cycles.
  - Full frame = 8×SCAN_DIV cycles.
  - Exactly one `dig_en` bit is low at any time after the first post-reset edge.
- Simultaneous events:
  - A write on the `cnt` wrap edge: the new `idx` and the new `disp` are both used at the next output update.
  - No glitch or mixed-nibble state is permitted.
- Reset mid-scan: all state returns to reset values immediately, with no dependence on the clock. Scanning restarts at digit 0.
- `we` held high for multiple cycles: the last captured `wdata` wins. Every cycle with a matching address performs a write.

## Test plan
- Reset and first digit: SCAN_DIV=4, hold `rst`=0, then release.
  - Required: `dig_en`/`seg` = FF/FF during reset.
  - Required: FE/C0 at the first edge after release.
  - Required: `dig_en` steps FE→FD→FB…→7F→FE every 4 cycles.
- Write and decode: write 32'h89AB_CDEF to FFFF_F000.
  - Required: over one frame, `seg` per digit 0..7 = 8E,86,A1,C6,83,88,90,80.
- Address filter: write 32'h1234_5678 to FFFF_F004 with `we`=1.
  - Required: `disp` is unchanged and the displayed frame is identical to the previous one.
- Write during active digit: while `idx`=0, write 32'h0000_0005.
  - Required: `seg` becomes 8'h92 exactly one cycle after the write edge, with `dig_en` still FE.
- Leading-zero blanking: LZ_BLANK=1, write 32'h0000_0120.
  - Required: digits 0..2 show C0, A4, F9.
  - Required: digits 3..7 show `seg`=FF.
  - Required: a subsequent write of 0 leaves only digit 0 showing C0.
- Async reset mid-frame: assert `rst`=0 between clock edges while `idx`=5.
  - Required: outputs go to FF/FF before the next edge.
  - Required: after release, scanning restarts at FE/C0.
